uart_mmio_port: RTL and testbench

//  Memory-mapped UART port on the I/O side of the MM/IO data mux (bus_a[12]=1).

---
 rtl/uart_mmio_port_pkg.sv | 27 ++
 rtl/uart_mmio_port_rx_fifo.sv | 43 ++++
 rtl/uart_mmio_port.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_mmio_port.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_port_pkg.sv
// Shared definitions for the memory-mapped UART port: FSM encodings,
// status bit positions and register select values.
package uart_mmio_port_pkg;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  localparam int STAT_RX_AVAIL = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_TX_BUSY  = 2;
  localparam int STAT_OVR      = 3;
  localparam int STAT_FERR     = 4;
  localparam int STAT_PERR     = 5;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  function automatic int div_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/uart_mmio_port_rx_fifo.sv
// Receive FIFO for the UART port: combinational head, pop applied before push
// so a full FIFO can accept a byte on the same cycle it is read.
module uart_rx_fifo #(
  parameter int AW = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  logic [7:0]  r_mem [2**AW];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_pop;
  logic        w_do_push;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign head      = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_mmio_port.sv
// Memory-mapped UART: 16x-oversampled RX into a FIFO, TX shift register, status byte.
// Define UART_PARITY_EN for 8E1 frames; otherwise frames are 8N1 and PERR reads 0.
module uart_mmio_port
  import uart_mmio_port_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int FIFO_AW  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic       rd,
  input  logic       wr,
  input  logic       s_mmio,
  input  logic       s_io,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int DIV   = CLK_FREQ / (BAUD * 16);
  localparam int DIV_W = div_width(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic r_rx_s1, r_rx_s2, r_rd_q, r_wr_q, r_tx, r_ovr, r_ferr;
  rx_state_t r_rx_state, w_rx_state_next;
  logic [3:0] r_rx_cnt, w_rx_cnt_next;
  logic [2:0] r_rx_bits, w_rx_bits_next;
  logic [7:0] r_rx_shift, w_rx_shift_next;
  tx_state_t r_tx_state, w_tx_state_next;
  logic [3:0] r_tx_cnt, w_tx_cnt_next;
  logic [2:0] r_tx_bits, w_tx_bits_next;
  logic [7:0] r_tx_shift, w_tx_shift_next;
  logic w_tx_next, w_tick, w_rd_edge, w_wr_edge, w_pop, w_stat_clr;
  logic w_push, w_ferr_set, w_full, w_empty, w_tx_busy, w_perr;
  logic [7:0] w_head, w_status;
`ifdef UART_PARITY_EN
  logic r_perr, r_tx_par, w_tx_par_next, w_perr_set;
  assign w_perr = r_perr;
`else
  assign w_perr = 1'b0;
`endif

  assign w_tick     = (r_div_cnt == DIV_LAST);
  assign w_rd_edge  = rd & ~r_rd_q & s_mmio;
  assign w_wr_edge  = wr & ~r_wr_q & s_mmio;
  assign w_pop      = w_rd_edge & (s_io == REG_DATA);
  assign w_stat_clr = w_rd_edge & (s_io == REG_STATUS);
  assign w_tx_busy  = (r_tx_state != TX_IDLE);
  assign tx         = r_tx;

  uart_rx_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk(clk), .rst(rst), .push(w_push), .pop(w_pop), .din(r_rx_shift),
    .head(w_head), .full(w_full), .empty(w_empty)
  );

  always_comb begin
    w_rx_state_next = r_rx_state;
    w_rx_cnt_next   = r_rx_cnt;
    w_rx_bits_next  = r_rx_bits;
    w_rx_shift_next = r_rx_shift;
    w_push          = 1'b0;
    w_ferr_set      = 1'b0;
`ifdef UART_PARITY_EN
    w_perr_set      = 1'b0;
`endif
    case (r_rx_state)
      RX_IDLE: if (!r_rx_s2) begin
        w_rx_state_next = RX_START;
        w_rx_cnt_next   = 4'd0;
      end
      RX_START: if (w_tick) begin
        w_rx_cnt_next = r_rx_cnt + 4'd1;
        if (r_rx_cnt == 4'd7) begin
          w_rx_cnt_next   = 4'd0;
          w_rx_bits_next  = 3'd0;
          w_rx_state_next = r_rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: if (w_tick) begin
        w_rx_cnt_next = r_rx_cnt + 4'd1;
        if (r_rx_cnt == 4'd15) begin
          w_rx_shift_next = {r_rx_s2, r_rx_shift[7:1]};
          w_rx_bits_next  = r_rx_bits + 3'd1;
`ifdef UART_PARITY_EN
          if (r_rx_bits == 3'd7) w_rx_state_next = RX_PARITY;
`else
          if (r_rx_bits == 3'd7) w_rx_state_next = RX_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: if (w_tick) begin
        w_rx_cnt_next = r_rx_cnt + 4'd1;
        if (r_rx_cnt == 4'd15) begin
          w_perr_set      = r_rx_s2 ^ (^r_rx_shift);
          w_rx_state_next = RX_STOP;
        end
      end
`endif
      RX_STOP: if (w_tick) begin
        w_rx_cnt_next = r_rx_cnt + 4'd1;
        if (r_rx_cnt == 4'd15) begin
          w_push          = r_rx_s2;
          w_ferr_set      = ~r_rx_s2;
          w_rx_state_next = RX_IDLE;
        end
      end
      default: w_rx_state_next = RX_IDLE;
    endcase
  end

  always_comb begin
    w_tx_state_next = r_tx_state;
    w_tx_cnt_next   = r_tx_cnt;
    w_tx_bits_next  = r_tx_bits;
    w_tx_shift_next = r_tx_shift;
    w_tx_next       = r_tx;
`ifdef UART_PARITY_EN
    w_tx_par_next   = r_tx_par;
`endif
    case (r_tx_state)
      TX_IDLE: if (w_wr_edge && s_io == REG_DATA) begin
        w_tx_shift_next = data_in;
        w_tx_state_next = TX_WAIT;
`ifdef UART_PARITY_EN
        w_tx_par_next   = ^data_in;
`endif
      end
      TX_WAIT: if (w_tick) begin
        w_tx_state_next = TX_START;
        w_tx_cnt_next   = 4'd0;
        w_tx_next       = 1'b0;
      end
      TX_START: if (w_tick) begin
        w_tx_cnt_next = r_tx_cnt + 4'd1;
        if (r_tx_cnt == 4'd15) begin
          w_tx_state_next = TX_DATA;
          w_tx_bits_next  = 3'd0;
          w_tx_next       = r_tx_shift[0];
        end
      end
      TX_DATA: if (w_tick) begin
        w_tx_cnt_next = r_tx_cnt + 4'd1;
        if (r_tx_cnt == 4'd15) begin
          if (r_tx_bits == 3'd7) begin
`ifdef UART_PARITY_EN
            w_tx_state_next = TX_PARITY;
            w_tx_next       = r_tx_par;
`else
            w_tx_state_next = TX_STOP;
            w_tx_next       = 1'b1;
`endif
          end else begin
            w_tx_bits_next  = r_tx_bits + 3'd1;
            w_tx_shift_next = r_tx_shift >> 1;
            w_tx_next       = r_tx_shift[1];
          end
        end
      end
      TX_PARITY: if (w_tick) begin
        w_tx_cnt_next = r_tx_cnt + 4'd1;
        if (r_tx_cnt == 4'd15) begin
          w_tx_state_next = TX_STOP;
          w_tx_next       = 1'b1;
        end
      end
      TX_STOP: if (w_tick) begin
        w_tx_cnt_next = r_tx_cnt + 4'd1;
        if (r_tx_cnt == 4'd15) w_tx_state_next = TX_IDLE;
      end
      default: w_tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt  <= '0;
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rd_q     <= 1'b0;
      r_wr_q     <= 1'b0;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bits  <= '0;
      r_rx_shift <= '0;
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bits  <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
      r_ovr      <= 1'b0;
      r_ferr     <= 1'b0;
`ifdef UART_PARITY_EN
      r_perr     <= 1'b0;
      r_tx_par   <= 1'b0;
`endif
    end else begin
      r_div_cnt  <= w_tick ? '0 : r_div_cnt + 1'b1;
      r_rx_s1    <= rx;
      r_rx_s2    <= r_rx_s1;
      r_rd_q     <= rd;
      r_wr_q     <= wr;
      r_rx_state <= w_rx_state_next;
      r_rx_cnt   <= w_rx_cnt_next;
      r_rx_bits  <= w_rx_bits_next;
      r_rx_shift <= w_rx_shift_next;
      r_tx_state <= w_tx_state_next;
      r_tx_cnt   <= w_tx_cnt_next;
      r_tx_bits  <= w_tx_bits_next;
      r_tx_shift <= w_tx_shift_next;
      r_tx       <= w_tx_next;
      // A sticky flag set on the same cycle as a STATUS read survives the read.
      r_ovr      <= (w_push & w_full & ~w_pop) | (r_ovr & ~w_stat_clr);
      r_ferr     <= w_ferr_set | (r_ferr & ~w_stat_clr);
`ifdef UART_PARITY_EN
      r_perr     <= w_perr_set | (r_perr & ~w_stat_clr);
      r_tx_par   <= w_tx_par_next;
`endif
    end
  end

  always_comb begin
    w_status                = 8'h00;
    w_status[STAT_RX_AVAIL] = ~w_empty;
    w_status[STAT_RX_FULL]  = w_full;
    w_status[STAT_TX_BUSY]  = w_tx_busy;
    w_status[STAT_OVR]      = r_ovr;
    w_status[STAT_FERR]     = r_ferr;
    w_status[STAT_PERR]     = w_perr;
  end

  assign data_out = (s_io == REG_STATUS) ? w_status : (w_empty ? 8'h00 : w_head);

endmodule

// File: tb/tb_uart_mmio_port.sv
// Bench for uart_mmio_port at one baud tick per clock (16 clk per bit).
// Reference: a byte queue plus sticky flags updated per whole frame/access.
module tb_uart_mmio_port;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic tx;
  logic rd = 1'b0;
  logic wr = 1'b0;
  logic s_mmio = 1'b0;
  logic s_io = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_q[$];
  logic m_ovr = 1'b0;
  logic m_ferr = 1'b0;
  logic m_perr = 1'b0;
`ifdef UART_PARITY_EN
  logic m_par_flip = 1'b0;
  logic tx_par_seen;
`endif

  uart_mmio_port #(.CLK_FREQ(1600000), .BAUD(100000), .FIFO_AW(4)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx), .rd(rd), .wr(wr),
    .s_mmio(s_mmio), .s_io(s_io), .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [7:0] model_status(input logic busy);
    return {2'b00, m_perr, m_ferr, m_ovr, busy, m_q.size() == DEPTH, m_q.size() != 0};
  endfunction

  task automatic bus_read(input logic sel, output logic [7:0] v);
    @(negedge clk);
    s_mmio = 1'b1; s_io = sel; rd = 1'b1;
    #1 v = data_out;
    repeat (3) @(negedge clk);
    rd = 1'b0; s_mmio = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [7:0] b);
    @(negedge clk);
    s_mmio = 1'b1; s_io = 1'b0; data_in = b; wr = 1'b1;
    repeat (4) @(negedge clk);
    wr = 1'b0; s_mmio = 1'b0;
  endtask

  task automatic read_status(input string tag, input logic busy);
    logic [7:0] v;
    bus_read(1'b1, v);
    chk(tag, v, model_status(busy));
    m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
  endtask

  task automatic read_data(input string tag);
    logic [7:0] v;
    logic [7:0] e;
    e = (m_q.size() != 0) ? m_q.pop_front() : 8'h00;
    bus_read(1'b0, v);
    chk(tag, v, e);
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rx = (^b) ^ m_par_flip;
    repeat (16) @(negedge clk);
    if (m_par_flip) m_perr = 1'b1;
`endif
    rx = stop_bit;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (24) @(negedge clk);
    if (!stop_bit) m_ferr = 1'b1;
    else if (m_q.size() == DEPTH) m_ovr = 1'b1;
    else m_q.push_back(b);
  endtask

  task automatic tx_decode(output logic [7:0] b, output logic start_ok,
                           output logic stop_ok, output logic found);
    found = 1'b0; b = 8'h00; start_ok = 1'b0; stop_ok = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (!tx) found = 1'b1;
    end
    if (found) begin
      repeat (7) @(negedge clk);
      start_ok = !tx;
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clk);
        b[i] = tx;
      end
`ifdef UART_PARITY_EN
      repeat (16) @(negedge clk);
      tx_par_seen = tx;
`endif
      repeat (16) @(negedge clk);
      stop_ok = tx;
    end
  endtask

  task automatic tx_frame(input logic [7:0] b, input logic busy_wr);
    logic [7:0] got;
    logic s_ok, p_ok, found;
    logic [7:0] v;
    int lows;
    fork
      tx_decode(got, s_ok, p_ok, found);
      begin
        bus_write(b);
        repeat (50) @(negedge clk);
        if (busy_wr) bus_write(~b);
        bus_read(1'b1, v);
        chk("tx_busy_status", v, model_status(1'b1));
        m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
      end
    join
    chk("tx_found", found, 1'b1);
    chk("tx_start", s_ok, 1'b1);
    chk("tx_byte", got, b);
    chk("tx_stop", p_ok, 1'b1);
`ifdef UART_PARITY_EN
    chk("tx_parity", tx_par_seen, ^b);
`endif
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (!tx) lows++;
    end
    chk("tx_single_frame", lows, 0);
    read_status("tx_idle_status", 1'b0);
  endtask

  initial begin
    logic [7:0] v;
    int lows;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_data_out", data_out, 8'h00);
    s_io = 1'b1;
    #1 chk("rst_status_out", data_out, 8'h00);
    s_io = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    read_status("post_rst_status", 1'b0);

    tx_frame(8'hA5, 1'b0);
    tx_frame(8'h3C, 1'b1);

    rx_send(8'h3C, 1'b1);
    read_status("rx_avail_status", 1'b0);
    read_data("rx_data_3c");
    read_status("rx_empty_status", 1'b0);
    read_data("rx_empty_data");

    for (int i = 0; i < DEPTH + 1; i++) rx_send(8'($urandom_range(0, 255)), 1'b1);
    read_status("fifo_full_ovr", 1'b0);
    rx_send(8'h11, 1'b1);
    read_status("full_still_ovr", 1'b0);
    for (int i = 0; i < DEPTH; i++) read_data("fifo_drain");
    read_status("fifo_drained", 1'b0);

    rx_send(8'h5A, 1'b0);
    read_status("ferr_status", 1'b0);
    read_status("ferr_cleared", 1'b0);
    @(negedge clk); rx = 1'b0;
    repeat (4) @(negedge clk); rx = 1'b1;
    repeat (200) @(negedge clk);
    read_status("glitch_status", 1'b0);

    rx_send(8'h99, 1'b1);
    @(negedge clk); s_mmio = 1'b0; s_io = 1'b0; rd = 1'b1;
    repeat (3) @(negedge clk); rd = 1'b0;
    @(negedge clk); s_io = 1'b0; data_in = 8'h00; wr = 1'b1;
    repeat (3) @(negedge clk); wr = 1'b0;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (!tx) lows++;
    end
    chk("unselected_wr_no_tx", lows, 0);
    read_data("unselected_rd_no_pop");

`ifdef UART_PARITY_EN
    m_par_flip = 1'b1;
    rx_send(8'h07, 1'b1);
    m_par_flip = 1'b0;
    read_status("perr_status", 1'b0);
    read_data("perr_data");
    read_status("perr_cleared", 1'b0);
`endif

    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 3))
        0: rx_send(8'($urandom_range(0, 255)), $urandom_range(0, 7) != 0);
        1: read_status("rand_status", 1'b0);
        2: read_data("rand_data");
        default: tx_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      endcase
    end

    bus_write(8'h00);
    repeat (60) @(negedge clk);
    chk("pre_rst_tx_low", tx, 1'b0);
    #2 rst = 1'b1;
    #1 chk("rst_async_tx", tx, 1'b1);
    m_q.delete(); m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    read_status("mid_rst_status", 1'b0);
    read_data("mid_rst_data");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
